// File: rtl/usb_pkg.sv
// Shared types and constants for the USB data buffer slice.
//   BUFFER_DEPTH  default byte capacity of the data buffer
//   xfer_size_t   host transfer size encoding (1, 2 or 4 bytes, one reserved code)
//   size_bytes()  maps a transfer size to its byte count (0 for the reserved code)
package usb_pkg;

  localparam int BUFFER_DEPTH = 64;

  typedef enum logic [1:0] {
    SIZE_1B   = 2'd0,
    SIZE_2B   = 2'd1,
    SIZE_4B   = 2'd2,
    SIZE_RSVD = 2'd3
  } xfer_size_t;

  function automatic logic [2:0] size_bytes(input xfer_size_t size);
    case (size)
      SIZE_1B: return 3'd1;
      SIZE_2B: return 3'd2;
      SIZE_4B: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/usb_buffer_mem.sv
// DEPTH x 8 register array behind the USB data buffer.
// Four byte write lanes and four byte read taps; lane/tap k addresses
// base + k, wrapping modulo DEPTH so multi-byte accesses straddle the end.
//   clk     system clock
//   wrEn    per-lane write enable, lane k writes wrData[8k+7:8k]
//   wrBase  address of lane 0 for writes
//   wrData  little-endian write bytes
//   rdBase  address of tap 0 for reads
//   rdData  little-endian read bytes (combinational)
module usb_buffer_mem
  import usb_pkg::*;
#(
  parameter int DEPTH = BUFFER_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    wrEn,
  input  logic [AW-1:0] wrBase,
  input  logic [31:0]   wrData,
  input  logic [AW-1:0] rdBase,
  output logic [31:0]   rdData
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, so clearing it would cost logic and buy nothing.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wrEn[k]) begin
        mem[wrBase + AW'(k)] <= wrData[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdData = '0;
    for (int k = 0; k < 4; k++) begin
      rdData[8*k +: 8] = mem[rdBase + AW'(k)];
    end
  end

endmodule

// File: rtl/usb_data_buffer.sv
// Byte-wide circular FIFO shared by the host and the USB endpoint.
// The host pushes/pops 1/2/4-byte little-endian words; usb_rx pushes single
// bytes and usb_tx pops single bytes. Reads are show-ahead.
//   clk, rst              clock, synchronous active-high reset
//   Clear                 flush; overrides all same-cycle pushes and pops
//   Store_Host_Data       push Host_Size bytes of Host_Data_In
//   Get_Host_Data         pop Host_Size bytes (shown on Host_Data_Out)
//   Host_Size             0=1B, 1=2B, 2=4B, 3=reserved (rejected)
//   Host_Data_In/Out      little-endian host words; out bytes past occupancy read 0
//   Store_RX_Packet_Data  push RX_Packet_Data
//   Get_TX_Packet_Data    pop one byte (TX_Packet_Data, 0 when empty)
//   Buffer_Occupancy      bytes stored, 0..DEPTH
//   Buffer_Error          one-cycle pulse the cycle after a rejected request
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH     = BUFFER_DEPTH,
  parameter int OCC_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Clear,
  input  logic                 Store_Host_Data,
  input  logic                 Get_Host_Data,
  input  logic [1:0]           Host_Size,
  input  logic [31:0]          Host_Data_In,
  output logic [31:0]          Host_Data_Out,
  input  logic                 Store_RX_Packet_Data,
  input  logic [7:0]           RX_Packet_Data,
  input  logic                 Get_TX_Packet_Data,
  output logic [7:0]           TX_Packet_Data,
  output logic [OCC_WIDTH-1:0] Buffer_Occupancy,
  output logic                 Buffer_Error
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]        rdPtr, wrPtr;
  logic [OCC_WIDTH-1:0] occ;
  logic                 errFlag;

  xfer_size_t hostSize;
  logic [2:0] hostBytes;
  logic       hostSizeBad;

  logic [2:0]         popN, popAcc, pushN, pushAcc;
  logic               popOk, popErr, pushOk, pushErr;
  logic [OCC_WIDTH:0] occAfterPop;
  logic               pushFits;
  logic [3:0]         wrEn;
  logic [31:0]        wrData, rdData;

  assign hostSize    = xfer_size_t'(Host_Size);
  assign hostBytes   = size_bytes(hostSize);
  assign hostSizeBad = (hostSize == SIZE_RSVD);

  // Pop arbitration and legality. TX wins; a colliding host pop is dropped
  // and flagged even though the TX pop itself may still proceed.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value held over and no latch is inferred.
  always_comb begin
    popN   = 3'd0;
    popOk  = 1'b0;
    popErr = 1'b0;
    if (Get_TX_Packet_Data) begin
      popN   = 3'd1;
      popOk  = (OCC_WIDTH'(popN) <= occ);
      popErr = Get_Host_Data | ~popOk;
    end else if (Get_Host_Data) begin
      popN = hostBytes;
      if (hostSizeBad) begin
        popErr = 1'b1;
      end else begin
        popOk  = (OCC_WIDTH'(popN) <= occ);
        popErr = ~popOk;
      end
    end
    popAcc = popOk ? popN : 3'd0;
  end

  // Push arbitration and legality; room is judged after the accepted pop.
  always_comb begin
    pushN       = 3'd0;
    pushOk      = 1'b0;
    pushErr     = 1'b0;
    wrData      = Host_Data_In;
    occAfterPop = {1'b0, occ} - (OCC_WIDTH+1)'(popAcc);
    if (Store_RX_Packet_Data) begin
      pushN  = 3'd1;
      wrData = {24'h0, RX_Packet_Data};
    end else if (Store_Host_Data) begin
      pushN = hostBytes;
    end
    pushFits = ((occAfterPop + (OCC_WIDTH+1)'(pushN)) <= (OCC_WIDTH+1)'(DEPTH));
    if (Store_RX_Packet_Data) begin
      pushOk  = pushFits;
      pushErr = Store_Host_Data | ~pushFits;
    end else if (Store_Host_Data) begin
      if (hostSizeBad) begin
        pushErr = 1'b1;
      end else begin
        pushOk  = pushFits;
        pushErr = ~pushFits;
      end
    end
    pushAcc = pushOk ? pushN : 3'd0;
  end

  always_comb begin
    wrEn = '0;
    for (int k = 0; k < 4; k++) begin
      wrEn[k] = ~Clear & (3'(k) < pushAcc);
    end
  end

  usb_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrBase (wrPtr),
    .wrData (wrData),
    .rdBase (rdPtr),
    .rdData (rdData)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || Clear) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      occ     <= '0;
      errFlag <= 1'b0;
    end else begin
      rdPtr   <= rdPtr + AW'(popAcc);
      wrPtr   <= wrPtr + AW'(pushAcc);
      occ     <= occ - OCC_WIDTH'(popAcc) + OCC_WIDTH'(pushAcc);
      errFlag <= popErr | pushErr;
    end
  end

  // Show-ahead outputs; bytes beyond the stored count are masked to zero so
  // stale memory never leaks out.
  always_comb begin
    Host_Data_Out = '0;
    for (int k = 0; k < 4; k++) begin
      if (occ > OCC_WIDTH'(k)) begin
        Host_Data_Out[8*k +: 8] = rdData[8*k +: 8];
      end
    end
  end

  assign TX_Packet_Data   = (occ != '0) ? rdData[7:0] : 8'h00;
  assign Buffer_Occupancy = occ;
  assign Buffer_Error     = errFlag;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer using a byte-queue scoreboard.
module tb_usb_data_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Clear = 1'b0;
  logic        Store_Host_Data = 1'b0;
  logic        Get_Host_Data = 1'b0;
  logic [1:0]  Host_Size = 2'd0;
  logic [31:0] Host_Data_In = '0;
  logic [31:0] Host_Data_Out;
  logic        Store_RX_Packet_Data = 1'b0;
  logic [7:0]  RX_Packet_Data = '0;
  logic        Get_TX_Packet_Data = 1'b0;
  logic [7:0]  TX_Packet_Data;
  logic [6:0]  Buffer_Occupancy;
  logic        Buffer_Error;

  int nVec  = 0;
  int nMiss = 0;

  logic [7:0] modelQ[$];

  usb_data_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .Clear                (Clear),
    .Store_Host_Data      (Store_Host_Data),
    .Get_Host_Data        (Get_Host_Data),
    .Host_Size            (Host_Size),
    .Host_Data_In         (Host_Data_In),
    .Host_Data_Out        (Host_Data_Out),
    .Store_RX_Packet_Data (Store_RX_Packet_Data),
    .RX_Packet_Data       (RX_Packet_Data),
    .Get_TX_Packet_Data   (Get_TX_Packet_Data),
    .TX_Packet_Data       (TX_Packet_Data),
    .Buffer_Occupancy     (Buffer_Occupancy),
    .Buffer_Error         (Buffer_Error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  // One clock cycle of stimulus. Show-ahead outputs are compared against the
  // scoreboard at the falling edge, registered outputs 1 time unit after the
  // rising edge.
  task automatic drive(input logic clr, input logic hst, input logic hget,
                       input logic [1:0] sz, input logic [31:0] hin,
                       input logic rxs, input logic [7:0] rxd, input logic txg);
    int         occ, popAcc, pushN;
    logic       expErr;
    logic [31:0] expHost;
    logic [7:0]  newBytes[$];
    Clear                = clr;
    Store_Host_Data      = hst;
    Get_Host_Data        = hget;
    Host_Size            = sz;
    Host_Data_In         = hin;
    Store_RX_Packet_Data = rxs;
    RX_Packet_Data       = rxd;
    Get_TX_Packet_Data   = txg;

    occ    = modelQ.size();
    popAcc = 0;
    expErr = 1'b0;
    if (txg) begin
      if (hget) expErr = 1'b1;
      if (occ >= 1) popAcc = 1;
      else expErr = 1'b1;
    end else if (hget) begin
      if (sz == 2'd3) expErr = 1'b1;
      else if (sizeBytes(sz) <= occ) popAcc = sizeBytes(sz);
      else expErr = 1'b1;
    end

    pushN = 0;
    if (rxs) begin
      if (hst) expErr = 1'b1;
      pushN = 1;
      newBytes.push_back(rxd);
    end else if (hst) begin
      if (sz == 2'd3) expErr = 1'b1;
      pushN = sizeBytes(sz);
      for (int k = 0; k < pushN; k++) newBytes.push_back(hin[8*k +: 8]);
    end
    if (pushN > 0 && (occ - popAcc + pushN) > 64) begin
      expErr = 1'b1;
      newBytes.delete();
    end

    @(negedge clk);
    if (txg) check("tx_data", {24'h0, TX_Packet_Data}, (occ > 0) ? {24'h0, modelQ[0]} : 32'h0);
    if (hget) begin
      expHost = '0;
      for (int k = 0; k < 4; k++) if (k < occ) expHost[8*k +: 8] = modelQ[k];
      check("host_data_out", Host_Data_Out, expHost);
    end

    if (clr) begin
      modelQ.delete();
      expErr = 1'b0;
    end else begin
      for (int k = 0; k < popAcc; k++) void'(modelQ.pop_front());
      foreach (newBytes[k]) modelQ.push_back(newBytes[k]);
    end

    @(posedge clk);
    #1;
    Clear                = 1'b0;
    Store_Host_Data      = 1'b0;
    Get_Host_Data        = 1'b0;
    Store_RX_Packet_Data = 1'b0;
    Get_TX_Packet_Data   = 1'b0;
    check("occupancy", {25'h0, Buffer_Occupancy}, modelQ.size());
    check("error", {31'h0, Buffer_Error}, {31'h0, expErr});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic hostPush(input logic [1:0] sz, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b0, sz, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic hostPop(input logic [1:0] sz);
    drive(1'b0, 1'b0, 1'b1, sz, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rxPush(input logic [7:0] d);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, d, 1'b0);
  endtask

  task automatic txPop();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelQ.delete();
    check("rst_occupancy", {25'h0, Buffer_Occupancy}, 32'h0);
    check("rst_error", {31'h0, Buffer_Error}, 32'h0);
    check("rst_tx_data", {24'h0, TX_Packet_Data}, 32'h0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    doReset();

    // T1: reset in the middle of traffic.
    for (int i = 0; i < 10; i++) rxPush(8'(8'h30 + i));
    check("t1_occ_before", {25'h0, Buffer_Occupancy}, 32'd10);
    doReset();

    // T2: host 4-byte write drained by TX.
    hostPush(2'd2, 32'hDDCCBBAA);
    check("t2_occ", {25'h0, Buffer_Occupancy}, 32'd4);
    check("t2_host_view", Host_Data_Out, 32'hDDCCBBAA);
    for (int i = 0; i < 4; i++) txPop();
    check("t2_occ_empty", {25'h0, Buffer_Occupancy}, 32'd0);
    txPop();                                        // underflow
    idle();                                         // error lasts one cycle

    // T3: full boundary.
    for (int i = 0; i < 16; i++) hostPush(2'd2, $urandom());
    check("t3_full", {25'h0, Buffer_Occupancy}, 32'd64);
    rxPush(8'hEE);                                  // overflow, rejected
    check("t3_err", {31'h0, Buffer_Error}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 8'h77, 1'b1);
    check("t3_swap_full", {25'h0, Buffer_Occupancy}, 32'd64);
    hostPush(2'd0, 32'h0000_0099);                  // still full
    for (int i = 0; i < 64; i++) txPop();

    // T4: host pop larger than occupancy.
    hostPush(2'd1, 32'h0000BBAA);
    rxPush(8'hCC);
    hostPop(2'd2);
    check("t4_host_view", Host_Data_Out, 32'h00CCBBAA);
    check("t4_err", {31'h0, Buffer_Error}, 32'd1);
    hostPop(2'd3);                                  // reserved size
    hostPush(2'd3, 32'h12345678);                   // reserved size
    hostPop(2'd1);                                  // AA, BB
    txPop();                                        // CC

    // T5: wrap-around; bring both pointers to 62 first.
    doReset();
    for (int i = 0; i < 15; i++) hostPush(2'd2, $urandom());
    hostPush(2'd1, $urandom());
    for (int i = 0; i < 62; i++) txPop();
    hostPush(2'd2, 32'h44332211);
    check("t5_wrap_view", Host_Data_Out, 32'h44332211);
    for (int i = 0; i < 4; i++) txPop();
    for (int i = 0; i < 3; i++) hostPush(2'd2, $urandom());
    hostPop(2'd2);
    hostPop(2'd1);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 32'hA1B2C3D4, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) txPop();

    // T6: push collision, host pop collision, then Clear.
    rxPush(8'h10);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h11223344, 1'b1, 8'h5A, 1'b0);
    check("t6_collide_err", {31'h0, Buffer_Error}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 8'h66, 1'b0);
    check("t6_clear_occ", {25'h0, Buffer_Occupancy}, 32'd0);
    check("t6_clear_err", {31'h0, Buffer_Error}, 32'd0);
    hostPush(2'd0, 32'h0000_00F0);
    txPop();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
